sound_sequencer: RTL and testbench
==================================

Name: sound_sequencer

Overview:
Event-to-tone sequencer that sits directly upstream of the speaker tone generator and drives its play_sound enable. Converts single-cycle game events into timed beep patterns: a short single beep for a block placement and a multi-beep pattern for game over. Uses a 1 ms timing base, so the game FSM only pulses event strobes and never times audio itself.

Parameters:
TICK_DIV, 100000, clock cycles per 1 ms timing tick (100 MHz clock); must be >= 1
BEEP_MS, 100, beep on-time in ticks; must be >= 1
GAP_MS, 50, silent gap between beeps of one pattern in ticks; must be >= 1
OVER_BEEPS, 3, number of beeps in the game-over pattern; range 1..15

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
place_evt  input  1  one-cycle strobe: block placed
over_evt  input  1  one-cycle strobe: game over
mute  input  1  level; 1 forces play_sound low without affecting timing
play_sound  output  1  registered enable to the tone generator; 1 = tone on
busy  output  1  registered; 1 while a pattern is in progress (BEEP or GAP state)

Behaviour:
- Reset (reset_n low, async): state IDLE, play_sound=0, busy=0, tick prescaler=0, ms counter=0, beeps_left=0. Release is synchronous to clock.
- Timing base: prescaler counts 0..TICK_DIV-1, width $clog2(TICK_DIV) (min 1). Tick = prescaler at TICK_DIV-1. Prescaler and ms counter (16 bits) clear to 0 on every state entry, so phase lengths are exact.
- States: IDLE, BEEP, GAP.
- IDLE: over_evt=1 -> BEEP, beeps_left=OVER_BEEPS. Else place_evt=1 -> BEEP, beeps_left=1. Both high together -> over wins.
- BEEP: lasts exactly BEEP_MS*TICK_DIV cycles. At the end, beeps_left decrements; if the result is 0 -> IDLE, else -> GAP.
- GAP: lasts exactly GAP_MS*TICK_DIV cycles, then -> BEEP.
- Latency: event sampled on edge N; play_sound and busy are high from the cycle after edge N. Outputs are registered decodes of the next state, so no combinational path from inputs to outputs.
- play_sound = (state==BEEP) && !mute, registered; mute takes effect one cycle after it changes. busy = state != IDLE, registered.
- Events while busy:
  - place_evt is ignored in any non-IDLE state.
  - over_evt during a place pattern (beeps_left was loaded as 1) restarts the sequence: -> BEEP, beeps_left=OVER_BEEPS, counters cleared.
  - over_evt during an over pattern is ignored.
  - An event coinciding with the final cycle of the last beep is handled as if the block were in IDLE, so back-to-back patterns run without a gap.
- No trailing gap after the final beep; busy and play_sound fall on the same cycle.
- Counter wrap: the ms counter compares with == against BEEP_MS-1/GAP_MS-1 on tick and never wraps within legal parameters.

Test Plan:
Parameters for all scenarios: TICK_DIV=4, BEEP_MS=3, GAP_MS=2, OVER_BEEPS=3, so a beep is 12 cycles and a gap is 8 cycles.
1. Reset mid-beep: assert reset_n=0 asynchronously between edges -> play_sound=0 and busy=0 immediately. After release, the block is IDLE and the next place_evt behaves normally.
2. place_evt pulse at edge N -> play_sound=1 on cycles N+1..N+12, busy identical, both 0 from N+13. A second place_evt at N+5 has no effect.
3. over_evt pulse -> three 12-cycle highs on play_sound, separated by two 8-cycle lows. busy stays high for all 52 cycles, then falls together with play_sound.
4. place_evt and over_evt in the same cycle -> 3-beep pattern. Separately, over_evt 6 cycles into a place beep -> the beep extends to a fresh 12 cycles and the full 3-beep pattern follows (52 cycles of busy from the over_evt).
5. mute=1 during an over pattern -> play_sound=0 throughout while busy timing is unchanged (52 cycles). mute=0 mid-second-beep -> play_sound goes high the following cycle for the remainder of that beep.
6. place_evt exactly on the final BEEP cycle of a prior place pattern -> play_sound stays high continuously for 24 cycles and busy never drops.

Source files
------------

// File: rtl/sound_sequencer.sv
// Event-to-tone sequencer: turns one-cycle game event strobes into timed
// beep patterns on play_sound, using a prescaled 1 ms timing tick.
module sound_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int BEEP_MS    = 100,
  parameter int GAP_MS     = 50,
  parameter int OVER_BEEPS = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic place_evt,
  input  logic over_evt,
  input  logic mute,
  output logic play_sound,
  output logic busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_ms;
  logic [3:0]    r_beeps_left;
  logic          r_place_pat;   // current pattern was started by a place event
  logic          r_play;
  logic          r_busy;

  state_t        w_state_next;
  logic [PW-1:0] w_presc_next;
  logic [15:0]   w_ms_next;
  logic [3:0]    w_beeps_next;
  logic          w_place_next;
  logic          w_enter;
  logic          w_start_over;
  logic          w_start_place;
  logic          w_tick;
  logic          w_beep_end;
  logic          w_gap_end;

  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_beep_end = (r_state == BEEP) && w_tick && (r_ms == 16'(BEEP_MS - 1));
  assign w_gap_end  = (r_state == GAP)  && w_tick && (r_ms == 16'(GAP_MS - 1));

  // Next-state, pattern bookkeeping and phase counters.
  always_comb begin
    w_state_next  = r_state;
    w_beeps_next  = r_beeps_left;
    w_place_next  = r_place_pat;
    w_enter       = 1'b0;
    w_start_over  = 1'b0;
    w_start_place = 1'b0;

    case (r_state)
      IDLE: begin
        if (over_evt)       w_start_over  = 1'b1;
        else if (place_evt) w_start_place = 1'b1;
      end
      BEEP: begin
        if (over_evt && r_place_pat) begin
          w_start_over = 1'b1;
        end else if (w_beep_end) begin
          if (r_beeps_left == 4'd1) begin
            // Final cycle of the last beep behaves like IDLE so a new
            // pattern can follow with no silent cycle.
            if (over_evt)       w_start_over  = 1'b1;
            else if (place_evt) w_start_place = 1'b1;
            else begin
              w_state_next = IDLE;
              w_beeps_next = r_beeps_left - 4'd1;
              w_enter      = 1'b1;
            end
          end else begin
            w_state_next = GAP;
            w_beeps_next = r_beeps_left - 4'd1;
            w_enter      = 1'b1;
          end
        end
      end
      GAP: begin
        if (over_evt && r_place_pat) begin
          w_start_over = 1'b1;
        end else if (w_gap_end) begin
          w_state_next = BEEP;
          w_enter      = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_enter      = 1'b1;
      end
    endcase

    if (w_start_over) begin
      w_state_next = BEEP;
      w_beeps_next = 4'(OVER_BEEPS);
      w_place_next = 1'b0;
      w_enter      = 1'b1;
    end else if (w_start_place) begin
      w_state_next = BEEP;
      w_beeps_next = 4'd1;
      w_place_next = 1'b1;
      w_enter      = 1'b1;
    end

    // Counters restart on every state entry so each phase length is exact.
    if (w_enter || (r_state == IDLE)) begin
      w_presc_next = '0;
      w_ms_next    = '0;
    end else if (w_tick) begin
      w_presc_next = '0;
      w_ms_next    = r_ms + 16'd1;
    end else begin
      w_presc_next = r_presc + PW'(1);
      w_ms_next    = r_ms;
    end
  end

  // State, counters and registered output decodes of the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_ms         <= '0;
      r_beeps_left <= '0;
      r_place_pat  <= 1'b0;
      r_play       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_ms         <= w_ms_next;
      r_beeps_left <= w_beeps_next;
      r_place_pat  <= w_place_next;
      r_play       <= (w_state_next == BEEP) && !mute;
      r_busy       <= (w_state_next != IDLE);
    end
  end

  assign play_sound = r_play;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer: stimulus pushes the expected
// outputs for each driven cycle; a monitor pops and compares after each edge.
module tb_sound_sequencer;

  logic clock;
  logic reset_n;
  logic place_evt;
  logic over_evt;
  logic mute;
  logic play_sound;
  logic busy;

  typedef struct {
    logic  play;
    logic  busy;
    string name;
    int    idx;
  } exp_t;

  exp_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_name = "none";
  int    cur_idx  = 0;

  sound_sequencer #(
    .TICK_DIV  (4),
    .BEEP_MS   (3),
    .GAP_MS    (2),
    .OVER_BEEPS(3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .place_evt (place_evt),
    .over_evt  (over_evt),
    .mute      (mute),
    .play_sound(play_sound),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one comparison per edge whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (play_sound !== e.play || busy !== e.busy) begin
          n_fail++;
          $display("FAIL %s step %0d: play_sound=%0b busy=%0b, expected play_sound=%0b busy=%0b",
                   e.name, e.idx, play_sound, busy, e.play, e.busy);
        end
      end
    end
  end

  // One driven cycle: inputs for the next edge plus the outputs expected after it.
  task automatic step(input logic p, input logic o, input logic m,
                      input logic ep, input logic eb);
    exp_t e;
    @(negedge clock);
    place_evt = p;
    over_evt  = o;
    mute      = m;
    e.play = ep;
    e.busy = eb;
    e.name = cur_name;
    e.idx  = cur_idx;
    cur_idx++;
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic m, input logic ep, input logic eb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, m, ep, eb);
  endtask

  task automatic begin_test(input string s);
    cur_name = s;
    cur_idx  = 0;
  endtask

  task automatic direct_check(input string s, input logic ep, input logic eb);
    n_tests++;
    if (play_sound !== ep || busy !== eb) begin
      n_fail++;
      $display("FAIL %s: play_sound=%0b busy=%0b, expected play_sound=%0b busy=%0b",
               s, play_sound, busy, ep, eb);
    end
  endtask

  task automatic over_pattern_tail(input int first_beep_left);
    run(first_beep_left, 1'b0, 1'b1, 1'b1);
    run(8, 1'b0, 1'b0, 1'b1);
    run(12, 1'b0, 1'b1, 1'b1);
    run(8, 1'b0, 1'b0, 1'b1);
    run(12, 1'b0, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    place_evt = 1'b0;
    over_evt  = 1'b0;
    mute      = 1'b0;
    reset_n   = 1'b0;
    #1;
    direct_check("reset_state", 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    begin_test("idle_after_reset");
    run(3, 1'b0, 1'b0, 1'b0);

    // Reset asserted between edges in the middle of a beep.
    begin_test("pre_reset_beep");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    direct_check("async_reset_mid_beep", 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    direct_check("held_in_reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    begin_test("idle_after_mid_reset");
    run(3, 1'b0, 1'b0, 1'b0);

    // Single place beep, second place ignored.
    begin_test("place_beep");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(6, 1'b0, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);

    // Game-over pattern.
    begin_test("over_pattern");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    over_pattern_tail(11);

    // Both events together: over wins.
    begin_test("both_events");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    over_pattern_tail(11);

    // over_evt six cycles into a place beep restarts as a full over pattern.
    begin_test("over_restarts_place");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    over_pattern_tail(11);

    // over_evt during an over pattern is ignored.
    begin_test("over_during_over");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    over_pattern_tail(6);

    // Muted over pattern, unmuted partway through the second beep.
    begin_test("mute_pattern");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run(11, 1'b1, 1'b0, 1'b1);
    run(8, 1'b1, 1'b0, 1'b1);
    run(5, 1'b1, 1'b0, 1'b1);
    run(7, 1'b0, 1'b1, 1'b1);
    run(8, 1'b0, 1'b0, 1'b1);
    run(12, 1'b0, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);

    // Back-to-back place beeps: new event on the final beep cycle.
    begin_test("back_to_back");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(11, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(11, 1'b0, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(negedge clock);
        budget--;
      end
      if (q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
